// File: rtl/tlb_pkg.sv
// Shared types for the TLB maintenance sequencer: TLB entry layout, op codes,
// FSM states and the CP0 EntryHi/EntryLo <-> entry conversion helpers.
package tlb_pkg;

  typedef enum logic [1:0] {
    TLBP  = 2'd0,
    TLBR  = 2'd1,
    TLBWI = 2'd2,
    TLBWR = 2'd3
  } tlb_op_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_READ,
    S_WRITE,
    S_RESP
  } seq_state_t;

  localparam logic [31:0] TLB_PROBE_MISS = 32'h8000_0000;

  // An entry is global only when both EntryLo halves carry G.
  function automatic tlb_entry_t pack_entry(input logic [31:0] hi,
                                            input logic [31:0] lo0,
                                            input logic [31:0] lo1);
    tlb_entry_t e;
    e.vpn2 = hi[31:13];
    e.asid = hi[7:0];
    e.g    = lo0[0] & lo1[0];
    e.pfn0 = lo0[25:6];
    e.c0   = lo0[5:3];
    e.d0   = lo0[2];
    e.v0   = lo0[1];
    e.pfn1 = lo1[25:6];
    e.c1   = lo1[5:3];
    e.d1   = lo1[2];
    e.v1   = lo1[1];
    return e;
  endfunction

  function automatic logic [31:0] entrylo(input logic [19:0] pfn, input logic [2:0] c,
                                          input logic d, input logic v, input logic g);
    return {6'b0, pfn, c, d, v, g};
  endfunction

endpackage

// File: rtl/tlb_op_seq_if.sv
// Request/response handshake between the CP0 pipeline (master) and the TLB
// op sequencer (slave).
interface tlb_op_seq_if;
  import tlb_pkg::*;

  logic        req_valid;
  logic        req_ready;
  tlb_op_t     req_op;
  logic        resp_valid;
  tlb_op_t     resp_op;
  logic [31:0] resp_index;
  logic [31:0] resp_entryhi;
  logic [31:0] resp_entrylo0;
  logic [31:0] resp_entrylo1;

  modport master (
    output req_valid, req_op,
    input  req_ready, resp_valid, resp_op, resp_index,
           resp_entryhi, resp_entrylo0, resp_entrylo1
  );

  modport slave (
    input  req_valid, req_op,
    output req_ready, resp_valid, resp_op, resp_index,
           resp_entryhi, resp_entrylo0, resp_entrylo1
  );
endinterface

// File: rtl/tlb_random_ctr.sv
// CP0 Random register: counts down from TLB_ENTRIES-1 to Wired and wraps.
// Only instantiated when TLB_RANDOM_EN is defined.
module tlb_random_ctr #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W-1:0] wired,
  output logic [IDX_W-1:0] random
);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TLB_ENTRIES - 1);

  logic [IDX_W-1:0] wired_q;
  logic             primed_q;
  logic             wired_wr;

  // A Wired write is seen as a change of its value; the first cycle after
  // reset has no valid history, so it cannot count as a write.
  assign wired_wr = primed_q && (wired != wired_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random   <= IDX_MAX;
      wired_q  <= '0;
      primed_q <= 1'b0;
    end else begin
      wired_q  <= wired;
      primed_q <= 1'b1;
      if (wired_wr || wired >= IDX_MAX || random <= wired)
        random <= IDX_MAX;
      else
        random <= random - 1'b1;
    end
  end
endmodule

// File: rtl/tlb_op_seq.sv
// TLB maintenance sequencer executing TLBP/TLBR/TLBWI/TLBWR on an external TLB.
// Define TLB_RANDOM_EN to build the CP0 Random counter used by TLBWR.
module tlb_op_seq
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             resetn,
  tlb_op_seq_if.slave      bus,
  input  logic             flush,
  input  logic [31:0]      entryhi,
  input  logic [31:0]      entrylo0,
  input  logic [31:0]      entrylo1,
  input  logic [31:0]      index,
  input  logic [IDX_W-1:0] wired,
  output logic [IDX_W-1:0] tlb_rd_idx,
  input  tlb_entry_t       tlb_rd_entry,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_wr_idx,
  output tlb_entry_t       tlb_wr_entry,
  output logic             busy,
  output logic [31:0]      random
);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TLB_ENTRIES - 1);

  seq_state_t       state_q, state_d;
  tlb_op_t          op_q;
  tlb_entry_t       entry_q;
  logic [IDX_W-1:0] idx_q, scan_q, rand_idx, acc_idx;
  logic             accept, hit, scan_last;
  logic             unused_bits;

`ifdef TLB_RANDOM_EN
  tlb_random_ctr #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_random (
    .clk    (clk),
    .resetn (resetn),
    .wired  (wired),
    .random (rand_idx)
  );
  assign acc_idx = (bus.req_op == TLBWR) ? rand_idx : index[IDX_W-1:0];
`else
  logic unused_wired;
  assign rand_idx     = IDX_MAX;
  assign acc_idx      = index[IDX_W-1:0];
  assign unused_wired = ^wired;
`endif

  // Only the low index bits address the TLB, so no access can go out of range.
  assign unused_bits = ^{entryhi[12:8], entrylo0[31:26], entrylo1[31:26], index[31:IDX_W]};

  assign accept    = bus.req_valid && bus.req_ready && !flush;
  assign hit       = (tlb_rd_entry.vpn2 == entry_q.vpn2) &&
                     (tlb_rd_entry.g || (tlb_rd_entry.asid == entry_q.asid));
  assign scan_last = (scan_q == IDX_MAX);

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign busy           = (state_q != S_IDLE);
  assign tlb_we         = (state_q == S_WRITE);
  assign tlb_wr_idx     = idx_q;
  assign tlb_wr_entry   = entry_q;
  assign tlb_rd_idx     = (state_q == S_SCAN) ? scan_q : idx_q;
  assign random         = 32'(rand_idx);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.req_op)
            TLBP:    state_d = S_SCAN;
            TLBR:    state_d = S_READ;
            default: state_d = S_WRITE;
          endcase
        end
      end
      S_SCAN:  if (flush) state_d = S_IDLE;
               else if (hit || scan_last) state_d = S_RESP;
      S_READ:  state_d = flush ? S_IDLE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: these are plain registers, not a memory array, so all are reset;
  // the response fields must read zero after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q              <= TLBP;
      entry_q           <= '0;
      idx_q             <= '0;
      scan_q            <= '0;
      bus.resp_op       <= TLBP;
      bus.resp_index    <= '0;
      bus.resp_entryhi  <= '0;
      bus.resp_entrylo0 <= '0;
      bus.resp_entrylo1 <= '0;
    end else begin
      if (accept) begin
        op_q    <= bus.req_op;
        entry_q <= pack_entry(entryhi, entrylo0, entrylo1);
        idx_q   <= acc_idx;
        scan_q  <= '0;
      end
      if (state_q == S_SCAN && !flush) begin
        scan_q <= scan_q + 1'b1;
        if (hit)            bus.resp_index <= 32'(scan_q);
        else if (scan_last) bus.resp_index <= TLB_PROBE_MISS;
      end
      if (state_q == S_READ && !flush) begin
        bus.resp_entryhi  <= {tlb_rd_entry.vpn2, 5'b0, tlb_rd_entry.asid};
        bus.resp_entrylo0 <= entrylo(tlb_rd_entry.pfn0, tlb_rd_entry.c0, tlb_rd_entry.d0,
                                     tlb_rd_entry.v0, tlb_rd_entry.g);
        bus.resp_entrylo1 <= entrylo(tlb_rd_entry.pfn1, tlb_rd_entry.c1, tlb_rd_entry.d1,
                                     tlb_rd_entry.v1, tlb_rd_entry.g);
      end
      if (state_d == S_RESP && state_q != S_RESP) bus.resp_op <= op_q;
    end
  end
endmodule

// File: tb/tb_tlb_op_seq.sv
// Self-checking bench for tlb_op_seq: table-driven ops with a response
// scoreboard, plus hand-written flush/reset sequences. Honours TLB_RANDOM_EN.
module tb_tlb_op_seq;
  import tlb_pkg::*;

  localparam int N  = 16;
  localparam int IW = 4;
`ifdef TLB_RANDOM_EN
  localparam logic RAND_ON = 1'b1;
`else
  localparam logic RAND_ON = 1'b0;
`endif

  typedef struct {
    tlb_op_t     op;
    logic [31:0] hi, lo0, lo1, idx;
    int          lat;
    logic        chk_idx;
    logic [31:0] exp_idx;
    logic        chk_ent;
    logic [31:0] exp_hi, exp_lo0, exp_lo1;
    logic        exp_we;
    logic        chk_wr;
    logic [IW-1:0] exp_wr;
  } vec_t;

  typedef struct {
    tlb_op_t     op;
    int          cyc;
    logic        chk_idx;
    logic [31:0] exp_idx;
    logic        chk_ent;
    logic [31:0] hi, lo0, lo1;
  } sb_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   entryhi = '0, entrylo0 = '0, entrylo1 = '0, index = '0;
  logic [IW-1:0] wired = 4'd4;
  logic [IW-1:0] tlb_rd_idx, tlb_wr_idx;
  tlb_entry_t    tlb_rd_entry, tlb_wr_entry;
  logic          tlb_we, busy;
  logic [31:0]   random;
  logic          load_mem = 1'b1;

  tlb_entry_t    tlb_mem [N];
  sb_t           sb [$];
  int            n_checks = 0, n_fail = 0;
  int            cyc_cnt = 0, we_cnt = 0;
  logic [IW-1:0] last_wr_idx = '0;

  tlb_op_seq_if bus ();

  tlb_op_seq #(.TLB_ENTRIES(N)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .flush        (flush),
    .entryhi      (entryhi),
    .entrylo0     (entrylo0),
    .entrylo1     (entrylo1),
    .index        (index),
    .wired        (wired),
    .tlb_rd_idx   (tlb_rd_idx),
    .tlb_rd_entry (tlb_rd_entry),
    .tlb_we       (tlb_we),
    .tlb_wr_idx   (tlb_wr_idx),
    .tlb_wr_entry (tlb_wr_entry),
    .busy         (busy),
    .random       (random)
  );

  always #5 clk = ~clk;

  function automatic tlb_entry_t init_entry(int i);
    tlb_entry_t e = '0;
    e.vpn2 = 19'h00010 + 19'(i);
    e.asid = 8'(i);
    e.pfn0 = 20'(2 * i);
    e.pfn1 = 20'(2 * i + 1);
    e.v0   = 1'b1;
    if (i == 5) begin e.vpn2 = 19'h12345; e.asid = 8'd3; end
    if (i == 2) begin e.vpn2 = 19'h0ABCD; e.asid = 8'd7; end
    if (i == 9) begin e.vpn2 = 19'h0ABCD; e.asid = 8'd1; e.g = 1'b1; end
    return e;
  endfunction

  // TLB array model: combinational read, write on the clock edge.
  assign tlb_rd_entry = tlb_mem[tlb_rd_idx];
  always @(posedge clk) begin
    if (load_mem) for (int i = 0; i < N; i++) tlb_mem[i] <= init_entry(i);
    else if (tlb_we) tlb_mem[tlb_wr_idx] <= tlb_wr_entry;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Response monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (resetn && tlb_we) begin
      we_cnt++;
      last_wr_idx = tlb_wr_idx;
    end
    if (resetn && bus.resp_valid) begin
      check("resp_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        sb_t e;
        e = sb.pop_front();
        check("resp_cycle", 32'(cyc_cnt), 32'(e.cyc));
        check("resp_op", 32'(bus.resp_op), 32'(e.op));
        if (e.chk_idx) check("resp_index", bus.resp_index, e.exp_idx);
        if (e.chk_ent) begin
          check("resp_entryhi", bus.resp_entryhi, e.hi);
          check("resp_entrylo0", bus.resp_entrylo0, e.lo0);
          check("resp_entrylo1", bus.resp_entrylo1, e.lo1);
        end
      end
    end
  end

  task automatic wait_ready();
    for (int w = 0; w < 40 && !bus.req_ready; w++) @(negedge clk);
    check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
  endtask

  // Drive one request at the current negedge; acceptance happens on the next edge.
  task automatic send(input vec_t v, input logic push);
    sb_t e;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    entryhi       = v.hi;
    entrylo0      = v.lo0;
    entrylo1      = v.lo1;
    index         = v.idx;
    e.op      = v.op;
    e.cyc     = cyc_cnt + 1 + v.lat;
    e.chk_idx = v.chk_idx;
    e.exp_idx = v.exp_idx;
    e.chk_ent = v.chk_ent;
    e.hi      = v.exp_hi;
    e.lo0     = v.exp_lo0;
    e.lo1     = v.exp_lo1;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 40 && sb.size() != 0; w++) @(negedge clk);
    check("resp_timeout", 32'(sb.size()), 32'd0);
  endtask

  localparam int NV = 11;
  vec_t vecs [NV];
  vec_t v;
  int   we0;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = TLBP;

    vecs[0]  = '{TLBP, {19'h12345, 5'd0, 8'd3}, 0, 0, 0, 6, 1, 32'd5, 0, 0, 0, 0, 0, 0, 4'd0};
    vecs[1]  = '{TLBP, {19'h12345, 5'd0, 8'd4}, 0, 0, 0, 16, 1, TLB_PROBE_MISS, 0, 0, 0, 0, 0, 0, 4'd0};
    vecs[2]  = '{TLBP, {19'h0ABCD, 5'd0, 8'd7}, 0, 0, 0, 3, 1, 32'd2, 0, 0, 0, 0, 0, 0, 4'd0};
    vecs[3]  = '{TLBP, {19'h0ABCD, 5'd0, 8'd2}, 0, 0, 0, 10, 1, 32'd9, 0, 0, 0, 0, 0, 0, 4'd0};
    vecs[4]  = '{TLBWI, 32'h2222_3F22, 32'hC000_ABCF, 32'h0123_4566, 32'h8000_0007, 1,
                 0, 0, 0, 0, 0, 0, 1, 1, 4'd7};
    vecs[5]  = '{TLBR, 0, 0, 0, 32'h0000_0007, 1, 0, 0,
                 1, 32'h2222_2022, 32'h0000_ABCE, 32'h0123_4566, 0, 0, 4'd0};
    vecs[6]  = '{TLBWI, 32'h6666_6044, 32'h0000_0041, 32'h0000_0081, 32'h0000_0003, 1,
                 0, 0, 0, 0, 0, 0, 1, 1, 4'd3};
    vecs[7]  = '{TLBR, 0, 0, 0, 32'hFFFF_FF23, 1, 0, 0,
                 1, 32'h6666_6044, 32'h0000_0041, 32'h0000_0081, 0, 0, 4'd0};
    vecs[8]  = '{TLBP, 32'h6666_6001, 0, 0, 0, 4, 1, 32'd3, 0, 0, 0, 0, 0, 0, 4'd0};
    vecs[9]  = '{TLBP, 32'h2222_3F22, 0, 0, 0, 8, 1, 32'd7, 0, 0, 0, 0, 0, 0, 4'd0};
    vecs[10] = '{TLBWR, 32'hAAAA_A011, 32'h3, 32'h5, 32'h0000_000C, 1,
                 0, 0, 0, 0, 0, 0, 1, !RAND_ON, 4'd12};

    // Reset state
    repeat (2) @(negedge clk);
    load_mem = 1'b0;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tlb_we", 32'(tlb_we), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_index", bus.resp_index, 32'd0);
    check("rst_resp_entryhi", bus.resp_entryhi, 32'd0);
    check("rst_resp_lo0", bus.resp_entrylo0, 32'd0);
    check("rst_resp_lo1", bus.resp_entrylo1, 32'd0);
    check("rst_resp_op", 32'(bus.resp_op), 32'd0);
    check("rst_random", random, 32'd15);
    resetn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      v   = vecs[k];
      we0 = we_cnt;
      send(v, 1'b1);
      drain();
      check("we_pulses", 32'(we_cnt - we0), 32'(v.exp_we));
      if (v.chk_wr) check("wr_idx", 32'(last_wr_idx), 32'(v.exp_wr));
    end

    // Flush in SCAN at T+3: back to IDLE at T+4, no response, no write.
    we0 = we_cnt;
    v = vecs[1];
    send(v, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_scan_ready", 32'(bus.req_ready), 32'd1);
    check("flush_scan_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("flush_scan_no_we", 32'(we_cnt - we0), 32'd0);
    check("flush_scan_idx_held", bus.resp_index, 32'd7);

    // Flush in READ: abandoned, response data held from last TLBR.
    v = vecs[5];
    v.idx = 32'd5;
    bus.req_valid = 1'b1;
    bus.req_op    = TLBR;
    index         = v.idx;
    @(negedge clk);
    bus.req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_read_ready", 32'(bus.req_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("flush_read_hi_held", bus.resp_entryhi, 32'h6666_6044);

    // Flush during WRITE and RESP is ignored.
    we0 = we_cnt;
    v = '{TLBWI, 32'h1357_9000, 32'h0000_0043, 32'h0000_0002, 32'h0000_0001, 1,
          0, 0, 0, 0, 0, 0, 1, 1, 4'd1};
    send(v, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b0;
    drain();
    check("flush_wr_we", 32'(we_cnt - we0), 32'd1);
    check("flush_wr_idx", 32'(last_wr_idx), 32'd1);

    // Flush in IDLE blocks acceptance.
    we0 = we_cnt;
    bus.req_valid = 1'b1;
    bus.req_op    = TLBWI;
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_busy", 32'(busy), 32'd0);
    bus.req_valid = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("flush_idle_no_we", 32'(we_cnt - we0), 32'd0);

`ifdef TLB_RANDOM_EN
    // Random counts 15..4 then wraps to 15; TLBWR uses the value at acceptance.
    begin
      logic [31:0] prev;
      prev = random;
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        check("random_seq", random, (prev == 32'd4) ? 32'd15 : prev - 32'd1);
        prev = random;
      end
      for (int w = 0; w < 40 && random != 32'd6; w++) @(negedge clk);
      check("random_reach6", random, 32'd6);
      we0 = we_cnt;
      v = '{TLBWR, 32'hBBBB_B000, 32'h1, 32'h1, 32'h0000_000E, 1,
            0, 0, 0, 0, 0, 0, 1, 1, 4'd6};
      send(v, 1'b1);
      drain();
      check("tlbwr_rand_we", 32'(we_cnt - we0), 32'd1);
      check("tlbwr_rand_idx", 32'(last_wr_idx), 32'd6);
    end
`endif

    // Reset asserted mid-SCAN: outputs return to reset values immediately.
    v = vecs[1];
    send(v, 1'b0);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    sb.delete();
    we0 = we_cnt;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrst_tlb_we", 32'(tlb_we), 32'd0);
    check("midrst_resp_index", bus.resp_index, 32'd0);
    check("midrst_random", random, 32'd15);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_we", 32'(we_cnt - we0), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
